// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a byte-wide RAM between fetch and load/store, sequencing little-endian multi-byte transfers
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_cancel,
  output logic              if_done,
  output logic [31:0]       if_inst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);
  typedef enum logic [1:0] {IDLE, RD_IF, RD_MEM, WR_MEM} state_t;
  state_t state_q, state_d;
  logic [2:0] cnt_q, n_q;
  logic [31:0] wdata_q, buf_q, buf_n;
  logic if_go, mem_go, last_rd, last_wr, done_if, done_rd, done_wr, step;
  always_comb begin
    if_go = if_req && !if_done;
    mem_go = mem_req && !mem_done;
    last_rd = cnt_q == n_q;
    last_wr = cnt_q + 3'd1 == n_q;
    done_if = state_q == RD_IF && last_rd && !if_cancel;
    done_rd = state_q == RD_MEM && last_rd;
    done_wr = state_q == WR_MEM && last_wr;
    step = cnt_q + 3'd1 < n_q && !(state_q == RD_IF && if_cancel);
    buf_n = buf_q;
    buf_n[{cnt_q[1:0] - 2'd1, 3'b000} +: 8] = ram_din;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = mem_go ? (mem_we ? WR_MEM : RD_MEM) : (if_go ? RD_IF : IDLE);
      RD_IF:   state_d = (if_cancel || last_rd) ? IDLE : RD_IF;
      RD_MEM:  state_d = last_rd ? IDLE : RD_MEM;
      default: state_d = last_wr ? IDLE : WR_MEM;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      n_q <= '0;
      wdata_q <= '0;
      buf_q <= '0;
      if_done <= 1'b0;
      if_inst <= '0;
      mem_done <= 1'b0;
      mem_rdata <= '0;
      ram_addr <= '0;
      ram_we <= 1'b0;
      ram_dout <= '0;
    end else begin
      state_q <= state_d;
      if_done <= done_if;
      mem_done <= done_rd || done_wr;
      if (done_if) if_inst <= buf_n;
      if (done_rd) mem_rdata <= buf_n;
      if (state_q == IDLE) begin
        cnt_q <= '0;
        buf_q <= '0;
        ram_we <= mem_go && mem_we;
        if (mem_go) begin
          ram_addr <= mem_addr;
          n_q <= mem_len == 2'd0 ? 3'd1 : (mem_len == 2'd1 ? 3'd2 : 3'd4);
          wdata_q <= mem_wdata;
          ram_dout <= mem_wdata[7:0];
        end else if (if_go) begin
          ram_addr <= if_addr;
          n_q <= 3'd4;
        end
      end else begin
        cnt_q <= cnt_q + 3'd1;
        if (cnt_q != 3'd0) buf_q <= buf_n;
        ram_we <= state_q == WR_MEM && !last_wr;
        if (step) begin
          ram_addr <= ram_addr + ADDR_W'(1);
          ram_dout <= wdata_q[{cnt_q[1:0] + 2'd1, 3'b000} +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector and corner-sequence bench for mem_arbiter
module tb_mem_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic if_req = 1'b0, if_cancel = 1'b0, if_done;
  logic [31:0] if_addr = '0, if_inst;
  logic mem_req = 1'b0, mem_we = 1'b0, mem_done;
  logic [1:0] mem_len = '0;
  logic [31:0] mem_addr = '0, mem_wdata = '0, mem_rdata;
  logic [31:0] ram_addr;
  logic ram_we;
  logic [7:0] ram_dout, ram_din;
  logic [7:0] ram [0:65535];
  logic [31:0] log_addr [0:20];
  logic log_we [0:20];
  logic [7:0] log_dout [0:20];
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  mem_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel), .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_dout(ram_dout), .ram_din(ram_din)
  );
  always @(posedge clk) begin
    ram_din <= ram[ram_addr[15:0]];
    if (ram_we) ram[ram_addr[15:0]] = ram_dout;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run(input bit fetch, input bit we, input logic [1:0] len, input logic [31:0] addr,
                     input logic [31:0] wdata, output int lat, output logic [31:0] data);
    @(posedge clk); #1;
    if (fetch) begin if_req = 1'b1; if_addr = addr; end
    else begin mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wdata; end
    lat = -1;
    data = 'x;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      log_addr[c] = ram_addr;
      log_we[c] = ram_we;
      log_dout[c] = ram_dout;
      if (fetch ? if_done : mem_done) begin
        lat = c;
        data = fetch ? if_inst : mem_rdata;
        break;
      end
    end
    if_req = 1'b0;
    mem_req = 1'b0;
  endtask
  typedef struct {
    bit fetch;
    bit we;
    logic [1:0] len;
    logic [31:0] addr;
    logic [31:0] wdata;
    int lat;
    logic [31:0] exp;
  } vec_t;
  vec_t tv [11];
  initial begin
    int lat, n, c, md, id;
    logic [31:0] d;
    bit seen;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    {ram[16'h0103], ram[16'h0102], ram[16'h0101], ram[16'h0100]} = 32'h00000513;
    ram[16'h0010] = 8'hFF;
    {ram[16'h2003], ram[16'h2002], ram[16'h2001], ram[16'h2000]} = 32'h44332211;
    {ram[16'h0001], ram[16'h0000], ram[16'hFFFF], ram[16'hFFFE]} = 32'hDDCCBBAA;
    {ram[16'h0052], ram[16'h0051]} = 16'h7E81;
    {ram[16'h0203], ram[16'h0202], ram[16'h0201], ram[16'h0200]} = 32'h01020304;
    tv[0]  = '{1'b1, 1'b0, 2'd2, 32'h00000100, 32'h0,        6, 32'h00000513};
    tv[1]  = '{1'b0, 1'b0, 2'd0, 32'h00000010, 32'h0,        3, 32'h000000FF};
    tv[2]  = '{1'b0, 1'b0, 2'd2, 32'h00002000, 32'h0,        6, 32'h44332211};
    tv[3]  = '{1'b0, 1'b0, 2'd1, 32'h00000051, 32'h0,        4, 32'h00007E81};
    tv[4]  = '{1'b0, 1'b0, 2'd2, 32'hFFFFFFFE, 32'h0,        6, 32'hDDCCBBAA};
    tv[5]  = '{1'b0, 1'b1, 2'd1, 32'h00003005, 32'h0000A55A, 3, 32'h0};
    tv[6]  = '{1'b0, 1'b0, 2'd2, 32'h00003004, 32'h0,        6, 32'h00A55A00};
    tv[7]  = '{1'b0, 1'b1, 2'd0, 32'h00004000, 32'h12345678, 2, 32'h0};
    tv[8]  = '{1'b0, 1'b1, 2'd3, 32'h00005000, 32'hCAFEF00D, 5, 32'h0};
    tv[9]  = '{1'b0, 1'b0, 2'd2, 32'h00005000, 32'h0,        6, 32'hCAFEF00D};
    tv[10] = '{1'b0, 1'b0, 2'd0, 32'h00004000, 32'h0,        3, 32'h00000078};
    repeat (3) @(posedge clk);
    #1;
    chk("rst if_done", {31'b0, if_done}, 32'h0);
    chk("rst mem_done", {31'b0, mem_done}, 32'h0);
    chk("rst ram_we", {31'b0, ram_we}, 32'h0);
    chk("rst ram_addr", ram_addr, 32'h0);
    chk("rst if_inst", if_inst, 32'h0);
    chk("rst mem_rdata", mem_rdata, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h100;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd2; mem_addr = 32'h2000;
    md = -1; id = -1;
    for (c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (mem_done) begin md = c; mem_req = 1'b0; end
      if (if_done) begin id = c; if_req = 1'b0; break; end
    end
    if_req = 1'b0; mem_req = 1'b0;
    chk("both mem_done cycle", md, 6);
    chk("both if_done cycle", id, 12);
    chk("both mem_rdata", mem_rdata, 32'h44332211);
    chk("both if_inst", if_inst, 32'h00000513);
    foreach (tv[i]) begin
      run(tv[i].fetch, tv[i].we, tv[i].len, tv[i].addr, tv[i].wdata, lat, d);
      n = tv[i].len == 2'd0 ? 1 : (tv[i].len == 2'd1 ? 2 : 4);
      chk($sformatf("vec%0d latency", i), lat, tv[i].lat);
      chk($sformatf("vec%0d first addr", i), log_addr[1], tv[i].addr);
      chk($sformatf("vec%0d last addr", i), log_addr[n], tv[i].addr + 32'(n - 1));
      if (!tv[i].we) chk($sformatf("vec%0d data", i), d, tv[i].exp);
      else chk($sformatf("vec%0d first byte", i), {24'b0, log_dout[1]}, {24'b0, tv[i].wdata[7:0]});
    end
    run(1'b0, 1'b1, 2'd1, 32'h3001, 32'h0000BEEF, lat, d);
    chk("sh latency", lat, 3);
    chk("sh we c1", {31'b0, log_we[1]}, 32'h1);
    chk("sh addr c1", log_addr[1], 32'h3001);
    chk("sh dout c1", {24'b0, log_dout[1]}, 32'hEF);
    chk("sh we c2", {31'b0, log_we[2]}, 32'h1);
    chk("sh addr c2", log_addr[2], 32'h3002);
    chk("sh dout c2", {24'b0, log_dout[2]}, 32'hBE);
    chk("sh we c3", {31'b0, log_we[3]}, 32'h0);
    chk("sh ram", {16'b0, ram[16'h3002], ram[16'h3001]}, 32'hBEEF);
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h100;
    id = -1;
    for (c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 3) if_cancel = 1'b1;
      if (c == 4) begin if_cancel = 1'b0; if_addr = 32'h200; end
      if (c == 5) chk("cancel ram_addr c5", ram_addr, 32'h200);
      if (if_done) begin id = c; if_req = 1'b0; break; end
    end
    if_req = 1'b0;
    chk("cancel if_done cycle", id, 10);
    chk("cancel if_inst", if_inst, 32'h01020304);
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd2; mem_addr = 32'h6000; mem_wdata = 32'h11223344;
    seen = 1'b0;
    for (c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (mem_done) seen = 1'b1;
      if (c == 2) begin rst = 1'b1; mem_req = 1'b0; end
      if (c == 3) begin
        chk("rst mid ram_we", {31'b0, ram_we}, 32'h0);
        chk("rst mid ram_addr", ram_addr, 32'h0);
        chk("rst mid if_inst", if_inst, 32'h0);
        rst = 1'b0;
      end
    end
    chk("rst mid no mem_done", {31'b0, seen}, 32'h0);
    chk("rst mid byte1 written", {24'b0, ram[16'h6001]}, 32'h33);
    chk("rst mid byte2 unwritten", {24'b0, ram[16'h6002]}, 32'h00);
    run(1'b1, 1'b0, 2'd2, 32'h100, 32'h0, lat, d);
    chk("post rst fetch latency", lat, 6);
    chk("post rst fetch data", d, 32'h00000513);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
